// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler for an 8:1 mux: registered sel/grant, bounded bursts,
// optional turnaround gap with sel held stable between grants.
module mux8_rr_scheduler #(
    parameter int MAX_BURST  = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       out_ready,
    output logic [2:0] sel,
    output logic [7:0] grant,
    output logic       out_valid,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);
    localparam logic [3:0] LAST_GAP  = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t     state_q, state_d;
    logic [2:0] sel_q, sel_d, ptr_q, ptr_d;
    logic [7:0] grant_q, grant_d;
    logic [3:0] beat_q, beat_d, gap_q, gap_d;
    logic       pick_vld;
    logic [2:0] pick_idx;
    logic       beat;

    // Descending scan so the smallest offset from ptr is the last (winning) write.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req[ptr_q + 3'(i)]) begin
                pick_vld = 1'b1;
                pick_idx = ptr_q + 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            grant_q <= 8'd0;
            ptr_q   <= 3'd0;
            beat_q  <= 4'd0;
            gap_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    sel_d   = pick_idx;
                    grant_d = 8'b1 << pick_idx;
                    beat_d  = 4'd0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Withdrawal and final beat in one cycle collapse into a single release.
                if (!req[sel_q] || (beat && beat_q == LAST_BEAT)) begin
                    grant_d = 8'd0;
                    ptr_d   = sel_q + 3'd1;
                    beat_d  = 4'd0;
                    gap_d   = 4'd0;
                    state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
                end else if (beat) begin
                    beat_d = beat_q + 4'd1;
                end
            end
            GAP: begin
                if (gap_q == LAST_GAP) state_d = IDLE;
                else                   gap_d   = gap_q + 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == GRANT) && req[sel_q];
        busy      = (state_q != IDLE);
    end

    assign beat  = out_valid && out_ready;
    assign sel   = sel_q;
    assign grant = grant_q;
endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Randomized scoreboard bench for mux8_rr_scheduler against an integer-level
// model of the grant/burst/gap rules.
module tb_mux8_rr_scheduler;
    localparam int MAXB = 4;
    localparam int GAPC = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'd0;
    logic       out_ready = 1'b0;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       out_valid;
    logic       busy;

    mux8_rr_scheduler #(.MAX_BURST(MAXB), .GAP_CYCLES(GAPC)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
        .sel(sel), .grant(grant), .out_valid(out_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] grant;
        logic [2:0] sel;
        logic       vld;
        logic       busy;
    } st_t;

    typedef struct {
        int cyc;
        int idx;
    } beat_t;

    st_t   st_q[$];
    beat_t beat_q[$];
    int    n_checks = 0;
    int    n_err = 0;
    int    cyc = 0;
    bit    mon_en = 1'b0;

    // Model: owner=-1 means no grant; gap_left>0 means turnaround in progress.
    int         m_owner, m_gap, m_ptr, m_sel, m_beats;
    logic [7:0] cur_req;
    logic       cur_rdy;
    bit         have_prev;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_gap = 0; m_ptr = 0; m_sel = 0; m_beats = 0;
    endtask

    function automatic st_t model_out(input logic [7:0] r);
        st_t s;
        s.grant = 8'd0;
        s.vld   = 1'b0;
        if (m_owner >= 0) begin
            s.grant = 8'd1 << m_owner;
            s.vld   = r[m_owner];
        end
        s.sel  = 3'(m_sel);
        s.busy = (m_owner >= 0) || (m_gap > 0);
        return s;
    endfunction

    task automatic model_step(input logic [7:0] r, input logic rdy);
        bit fire;
        if (m_owner >= 0) begin
            fire = r[m_owner] && rdy;
            if (!r[m_owner] || (fire && m_beats + 1 == MAXB)) begin
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
                m_beats = 0;
                m_gap   = GAPC;
            end else if (fire) begin
                m_beats++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (m_owner < 0 && r[(m_ptr + k) % 8]) begin
                    m_owner = (m_ptr + k) % 8;
                    m_sel   = m_owner;
                    m_beats = 0;
                end
            end
        end
    endtask

    task automatic push_expected();
        st_t   s;
        beat_t b;
        s = model_out(cur_req);
        st_q.push_back(s);
        if (s.vld && cur_rdy) begin
            b.cyc = cyc;
            b.idx = m_owner;
            beat_q.push_back(b);
        end
    endtask

    task automatic step(input logic [7:0] r, input logic rdy);
        @(posedge clk);
        #1;
        if (have_prev) model_step(cur_req, cur_rdy);
        req = r; out_ready = rdy;
        cur_req = r; cur_rdy = rdy; have_prev = 1'b1;
        push_expected();
    endtask

    // Asynchronous reset mid-cycle; outputs must clear with no clock edge.
    task automatic do_reset();
        mon_en = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_sel", int'(sel), 0);
        chk("rst_grant", int'(grant), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        st_q.delete();
        beat_q.delete();
        model_reset();
        req = 8'd0; out_ready = 1'b0;
        cur_req = 8'd0; cur_rdy = 1'b0; have_prev = 1'b1;
        push_expected();
        mon_en = 1'b1;
    endtask

    // Status monitor: every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (st_q.size() == 0) begin
                chk("status_queue_empty", 1, 0);
            end else begin
                st_t s;
                s = st_q.pop_front();
                chk("grant", int'(grant), int'(s.grant));
                chk("sel", int'(sel), int'(s.sel));
                chk("out_valid", int'(out_valid), int'(s.vld));
                chk("busy", int'(busy), int'(s.busy));
            end
        end
    end

    // Beat monitor: only when the DUT presents a completed beat.
    always @(negedge clk) begin
        if (mon_en) begin
            while (beat_q.size() > 0 && beat_q[0].cyc < cyc) begin
                chk("missed_beat_cycle", cyc, beat_q[0].cyc);
                void'(beat_q.pop_front());
            end
            if (out_valid && out_ready) begin
                if (beat_q.size() == 0) begin
                    chk("unexpected_beat_sel", int'(sel), -1);
                end else begin
                    beat_t b;
                    b = beat_q.pop_front();
                    chk("beat_idx", int'(sel), b.idx);
                    chk("beat_cycle", cyc, b.cyc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        model_reset();
        have_prev = 1'b0;
        do_reset();

        // Two requesters, continuous ready.
        repeat (25) step(8'h22, 1'b1);
        // Full load, ptr wrap.
        repeat (50) step(8'hFF, 1'b1);
        // Stall on requester 3.
        repeat (3) step(8'h08, 1'b1);
        repeat (10) step(8'h08, 1'b0);
        repeat (8) step(8'h08, 1'b1);
        repeat (3) step(8'h00, 1'b1);
        // Requester 6 withdraws after 2 beats; next grant wraps to 0.
        repeat (3) step(8'h40, 1'b1);
        repeat (6) step(8'h03, 1'b1);
        repeat (4) step(8'h00, 1'b1);
        // Lone requester 7, then drop on the 4th beat.
        repeat (20) step(8'h80, 1'b1);
        repeat (2) step(8'h80, 1'b1);
        repeat (6) step(8'h00, 1'b1);

        // Async reset while requester 5 is granted and stalled.
        repeat (3) step(8'h20, 1'b0);
        do_reset();

        r = 8'($urandom);
        repeat (1500) begin
            if ($urandom_range(0, 9) == 0) r = 8'($urandom);
            if ($urandom_range(0, 19) == 0) r = 8'd0;
            step(r, $urandom_range(0, 9) < 7);
        end

        repeat (2) step(8'h00, 1'b0);
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        chk("beats_left_over", beat_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
